// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and strobe/ready sequencer for the shared memory bus.
// Adds a per-transfer timeout so a dead slave cannot hang the requesters.
module mem_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_err,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_bus_clk,
  output logic                      o_bus_we,
  output logic [ADDR_W-1:0]         o_bus_addr,
  output logic [DATA_W-1:0]         o_bus_data,
  input  logic [DATA_W-1:0]         i_bus_data,
  input  logic                      i_bus_data_ready
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RELEASE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_last, w_last_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_bus_clk, w_bus_clk_nxt;
  logic                r_bus_we, w_bus_we_nxt;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_nxt;
  logic [DATA_W-1:0]   r_bus_data, w_bus_data_nxt;

  logic                w_found;
  logic [IW-1:0]       w_win;

  // Rotating priority search starting just after the last winner
  always_comb begin
    logic [IW:0] v_j;
    v_j     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_j = {1'b0, r_last} + (IW+1)'(i + 1);
      if (v_j >= NR) v_j = v_j - NR;
      if (!w_found && i_req[v_j[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_j[IW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_gnt_nxt      = r_gnt;
    w_done_nxt     = '0;
    w_err_nxt      = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_bus_clk_nxt  = r_bus_clk;
    w_bus_we_nxt   = r_bus_we;
    w_bus_addr_nxt = r_bus_addr;
    w_bus_data_nxt = r_bus_data;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = STROBE;
          w_bus_clk_nxt  = 1'b1;
          w_gnt_nxt      = ONE << w_win;
          w_last_nxt     = w_win;
          w_cnt_nxt      = '0;
          w_bus_we_nxt   = i_req_we[w_win];
          w_bus_addr_nxt = i_req_addr[int'(w_win)*ADDR_W +: ADDR_W];
          w_bus_data_nxt = i_req_wdata[int'(w_win)*DATA_W +: DATA_W];
        end
      end
      STROBE: begin
        if (i_bus_data_ready) begin
          w_state_nxt   = RELEASE;
          w_bus_clk_nxt = 1'b0;
          w_done_nxt    = r_gnt;
          if (!r_bus_we) w_rdata_nxt = i_bus_data;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt   = RELEASE;
          w_bus_clk_nxt = 1'b0;
          w_done_nxt    = r_gnt;
          w_err_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RELEASE: begin
        // Wait for ready low so a stale ack never ends the next transfer
        if (!i_bus_data_ready) begin
          w_state_nxt  = IDLE;
          w_gnt_nxt    = '0;
          w_bus_we_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_last     <= IW'(NUM_REQ - 1);
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_bus_clk  <= 1'b0;
      r_bus_we   <= 1'b0;
      r_bus_addr <= '0;
      r_bus_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_bus_clk  <= w_bus_clk_nxt;
      r_bus_we   <= w_bus_we_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_bus_data <= w_bus_data_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_bus_clk  = r_bus_clk;
  assign o_bus_we   = r_bus_we;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_data = r_bus_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random transfers
// checked against a transaction-level rotation/timeout model.
module tb_mem_bus_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic [NR-1:0]    i_req = '0;
  logic [NR-1:0]    i_req_we = '0;
  logic [NR*AW-1:0] i_req_addr = '0;
  logic [NR*DW-1:0] i_req_wdata = '0;
  logic [NR-1:0]    o_gnt;
  logic [NR-1:0]    o_done;
  logic             o_err;
  logic [DW-1:0]    o_rdata;
  logic             o_bus_clk;
  logic             o_bus_we;
  logic [AW-1:0]    o_bus_addr;
  logic [DW-1:0]    o_bus_data;
  logic [DW-1:0]    i_bus_data = '0;
  logic             i_bus_data_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int m_last = NR - 1;
  logic [DW-1:0] m_rdata = '0;

  mem_bus_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .i_req_we(i_req_we),
    .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_gnt(o_gnt),
    .o_done(o_done),
    .o_err(o_err),
    .o_rdata(o_rdata),
    .o_bus_clk(o_bus_clk),
    .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr),
    .o_bus_data(o_bus_data),
    .i_bus_data(i_bus_data),
    .i_bus_data_ready(i_bus_data_ready)
  );

  always #5 i_clk = ~i_clk;

  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++) begin
      int c;
      c = (last + i) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < NR; k++) begin
      i_req_addr[k*AW +: AW]  = $urandom;
      i_req_wdata[k*DW +: DW] = $urandom;
      i_req_we[k]             = 1'($urandom_range(0, 1));
    end
  endtask

  // One full transfer from IDLE; dly = cycles before slave acks
  task automatic run_xfer(input logic [NR-1:0] reqv, input int dly,
                          input int hold, input bit keep,
                          input logic [DW-1:0] rdat);
    int w;
    int n;
    bit rdy;
    bit exp_err;
    logic [NR-1:0] oh;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ewe;
    w = pick(reqv, m_last);
    oh = '0;
    oh[w] = 1'b1;
    ea = i_req_addr[w*AW +: AW];
    ed = i_req_wdata[w*DW +: DW];
    ewe = i_req_we[w];
    i_req = reqv;
    i_bus_data = rdat;
    i_bus_data_ready = 1'b0;
    @(posedge i_clk); #1;
    m_last = w;
    n_vec++;
    if (o_gnt !== oh || o_bus_clk !== 1'b1) begin
      n_bad++;
      $display("FAIL grant: gnt=%b clk=%b required gnt=%b clk=1",
               o_gnt, o_bus_clk, oh);
    end
    n_vec++;
    if ({o_bus_we, o_bus_addr, o_bus_data} !== {ewe, ea, ed}) begin
      n_bad++;
      $display("FAIL latch: we=%b a=%h d=%h required we=%b a=%h d=%h",
               o_bus_we, o_bus_addr, o_bus_data, ewe, ea, ed);
    end
    if (!keep) i_req = '0;
    n = 0;
    exp_err = 1'b0;
    while (1) begin
      rdy = (n >= dly);
      i_bus_data_ready = rdy;
      @(posedge i_clk); #1;
      n++;
      if (rdy) begin
        exp_err = 1'b0;
        if (!ewe) m_rdata = rdat;
        break;
      end
      if (n == TO) begin
        exp_err = 1'b1;
        break;
      end
      n_vec++;
      if (o_bus_clk !== 1'b1 || o_done !== '0) begin
        n_bad++;
        $display("FAIL strobe: clk=%b done=%b required clk=1 done=0 cyc=%0d",
                 o_bus_clk, o_done, n);
      end
    end
    n_vec++;
    if (o_bus_clk !== 1'b0 || o_done !== oh || o_err !== exp_err ||
        o_rdata !== m_rdata) begin
      n_bad++;
      $display("FAIL done: clk=%b done=%b err=%b rd=%h required 0 %b %b %h",
               o_bus_clk, o_done, o_err, o_rdata, oh, exp_err, m_rdata);
    end
    if (!exp_err) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge i_clk); #1;
        n_vec++;
        if (o_bus_clk !== 1'b0 || o_done !== '0 || o_gnt !== oh) begin
          n_bad++;
          $display("FAIL release: clk=%b done=%b gnt=%b required 0 0 %b",
                   o_bus_clk, o_done, o_gnt, oh);
        end
      end
    end
    i_bus_data_ready = 1'b0;
    @(posedge i_clk); #1;
    n_vec++;
    if (o_gnt !== '0 || o_bus_we !== 1'b0 || o_done !== '0 ||
        o_bus_clk !== 1'b0 || o_bus_addr !== ea || o_rdata !== m_rdata) begin
      n_bad++;
      $display("FAIL idle: gnt=%b we=%b done=%b clk=%b a=%h rd=%h req a=%h rd=%h",
               o_gnt, o_bus_we, o_done, o_bus_clk, o_bus_addr, o_rdata,
               ea, m_rdata);
    end
  endtask

  task automatic apply_reset();
    @(posedge i_clk); #1;
    i_req = '0;
    i_bus_data_ready = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_last = NR - 1;
    m_rdata = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({o_gnt, o_done, o_err, o_rdata, o_bus_clk, o_bus_we,
         o_bus_addr, o_bus_data} !== '0) begin
      n_bad++;
      $display("FAIL reset: gnt=%b done=%b err=%b rd=%h clk=%b we=%b a=%h d=%h required all 0",
               o_gnt, o_done, o_err, o_rdata, o_bus_clk, o_bus_we,
               o_bus_addr, o_bus_data);
    end
  endtask

  task automatic test_single_read();
    fill_rand();
    i_req_we[1] = 1'b0;
    i_req_addr[1*AW +: AW] = 32'h0000_1234;
    run_xfer(3'b010, 2, 0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_write();
    fill_rand();
    i_req_we[0] = 1'b1;
    i_req_addr[0*AW +: AW] = 32'h0000_0080;
    i_req_wdata[0*DW +: DW] = 32'h0000_00A5;
    run_xfer(3'b001, 1, 0, 1'b0, 32'h1357_9BDF);
  endtask

  task automatic test_contention();
    apply_reset();
    fill_rand();
    for (int t = 0; t < 6; t++) begin
      run_xfer(3'b111, 0, 0, 1'b1, $urandom);
    end
    i_req = '0;
  endtask

  task automatic test_timeout();
    fill_rand();
    i_req_we[2] = 1'b0;
    run_xfer(3'b100, TO, 0, 1'b0, 32'hFFFF_0000);
  endtask

  task automatic test_slow_release();
    fill_rand();
    run_xfer(3'b001, 0, 5, 1'b1, $urandom);
    run_xfer(3'b001, 1, 0, 1'b0, $urandom);
  endtask

  task automatic test_async_reset();
    fill_rand();
    i_req = 3'b001;
    @(posedge i_clk); #1;
    i_req = '0;
    n_vec++;
    if (o_bus_clk !== 1'b1 || o_gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL pre_reset: clk=%b gnt=%b required 1 001",
               o_bus_clk, o_gnt);
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_vec++;
    if (o_bus_clk !== 1'b0 || o_gnt !== '0 || o_done !== '0) begin
      n_bad++;
      $display("FAIL async_reset: clk=%b gnt=%b done=%b required 0 0 0",
               o_bus_clk, o_gnt, o_done);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_last = NR - 1;
    m_rdata = '0;
    run_xfer(3'b111, 0, 0, 1'b0, $urandom);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [NR-1:0] r;
      fill_rand();
      r = NR'($urandom_range(1, (1 << NR) - 1));
      run_xfer(r, $urandom_range(0, TO), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_slow_release();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and sequencer for the single external memory bus (`o_bus_clk`/`o_bus_we`/`o_bus_addr`/`o_bus_data`, `i_bus_data`/`i_bus_data_ready`) driven by the CPU core. It shares the bus between NUM_REQ requesters: CPU data port, DMA engine and video fetch. Each transfer follows the same strobe/ready handshake the memory side already implements. It sits between the requesters and the bus pins, and adds a per-transfer timeout so a dead slave cannot hang the system.

## Interface
- NUM_REQ, 3, number of requesters; index 0..NUM_REQ-1; 2..8 supported
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles `o_bus_clk` stays high awaiting ready; 1..65535
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  NUM_REQ  per-requester request; held high until that requester's done
- i_req_we  in  NUM_REQ  per-requester write enable
- i_req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester k at bits [k*ADDR_W +: ADDR_W]
- i_req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- o_gnt  out  NUM_REQ  one-hot, high for the granted requester for the whole transfer
- o_done  out  NUM_REQ  one-cycle pulse to the granted requester at transfer end
- o_err  out  1  valid with o_done; 1 = transfer timed out
- o_rdata  out  DATA_W  read data; holds last captured value
- o_bus_clk  out  1  bus strobe
- o_bus_we  out  1  bus write enable
- o_bus_addr  out  ADDR_W  bus address
- o_bus_data  out  DATA_W  bus write data
- i_bus_data  in  DATA_W  bus read data
- i_bus_data_ready  in  1  slave ready/acknowledge

## Operation
- States: IDLE, STROBE, RELEASE.
- IDLE to STROBE:
  - Triggers when any `i_req` bit is high.
  - Winner is the first requester with `i_req` set, searching from `last+1` mod NUM_REQ and wrapping.
  - The winner's we/addr/wdata are latched into `o_bus_we`/`o_bus_addr`/`o_bus_data`.
  - `o_bus_clk` goes to 1, `o_gnt` goes one-hot for the winner, `last` takes the winner index, and the timeout counter clears.
- STROBE to RELEASE, normal completion:
  - Triggers when `i_bus_data_ready`=1.
  - `o_bus_clk` goes to 0 and `o_done[winner]` pulses with `o_err`=0.
  - On a read (we=0), `o_rdata` captures `i_bus_data`. On a write, `o_rdata` is unchanged.
- STROBE to RELEASE, timeout:
  - Triggers when the counter reaches TIMEOUT-1 with ready still 0.
  - `o_bus_clk` goes to 0 and `o_done[winner]` pulses with `o_err`=1. `o_rdata` is unchanged.
- RELEASE to IDLE:
  - Triggers when `i_bus_data_ready`=0.
  - `o_gnt` clears and `o_bus_we` goes to 0. `o_bus_addr`/`o_bus_data` hold their values.
  - If ready is still 1, stay in RELEASE.
- Requester inputs are ignored outside IDLE. A requester that drops `i_req` mid-transfer still gets its transfer completed and its done pulse.
- Only the granted requester ever sees `o_done`. `o_done` is zero everywhere except the single completion cycle.
- Every requester's i_req_addr/i_req_we/i_req_wdata must be stable whenever its `i_req` is high. Only the winner's values are latched, at the IDLE→STROBE edge.

## Timing
- Reset, asynchronous:
  - State IDLE, `last`=NUM_REQ-1 (so requester 0 wins first), counter 0.
  - All outputs 0: `o_gnt`, `o_done`, `o_err`, `o_rdata`, `o_bus_clk`, `o_bus_we`, `o_bus_addr`, `o_bus_data`.
  - Reset mid-transfer drops `o_bus_clk` immediately. No done pulse is issued.
- Request to strobe:
  - With `i_req` high in IDLE at edge k, `o_bus_clk`/`o_gnt` are high after edge k.
  - Minimum transfer: strobe at k, ready seen at edge k+1, done after k+1.
- Done:
  - Ready sampled high at edge m gives `o_done`/`o_rdata`/`o_err` valid for exactly the cycle after m.
  - A requester dropping `i_req` in response to done (registered at edge m+1) is never re-granted for the same request.
- Back-to-back:
  - Minimum period is 3 cycles: STROBE, RELEASE, IDLE-arbitrate.
  - A requester still holding `i_req` after its done gets a new transfer only if no other requester wins the rotation.
- Timeout: `o_bus_clk` is high for exactly TIMEOUT cycles, then released.
- Ready already high when entering STROBE: it is accepted at the first STROBE edge. A stale ready from a prior transfer cannot occur, because RELEASE waits for ready low.
- Simultaneous requests from all requesters: grants rotate 0,1,2,0,… with no starvation. Worst-case wait is (NUM_REQ-1) transfers.

## Test plan
- Single read: requester 1, addr 0x0000_1234, slave ready 2 cycles after strobe with data 0xDEAD_BEEF. Required: `o_bus_addr`=0x1234, `o_bus_we`=0, `o_done`=3'b010, `o_rdata`=0xDEAD_BEEF, `o_err`=0.
- Write: requester 0, we=1, addr 0x80, data 0x0000_00A5, ready after 1 cycle. Required: `o_bus_we`=1, `o_bus_data`=0xA5 while `o_bus_clk`=1, `o_done`=3'b001, `o_rdata` unchanged.
- Contention: all three requesters hold `i_req` continuously from reset. Required: `o_gnt` sequence 001,010,100,001,010,100, each transfer 3 cycles apart with ready returned immediately.
- Timeout: TIMEOUT=4, requester 2 reads, ready never asserted. Required: `o_bus_clk` high exactly 4 cycles, then `o_done`=3'b100 with `o_err`=1, then state IDLE.
- Slow release: slave holds ready high 5 cycles after the ack while requester 0 re-requests. Required: no new strobe until 1 cycle after ready falls.
- Async reset asserted mid-STROBE. Required: `o_bus_clk`, `o_gnt`, `o_done` all 0 immediately; the next request from requester 0 is granted first.
